pdm_cic_decimator: RTL and testbench
====================================

# pdm_cic_decimator

Front-end microphone stage that drives the on-board PDM microphone clock, samples the 1-bit PDM stream and decimates it through a 4th-order CIC filter into signed 16-bit PCM samples. Each sample is announced with a one-cycle `data_mic_valid` strobe. It feeds the audio capture block, which latches `data_mic` on every strobe and writes frames of 1024 samples into the FFT input RAM.

## Interface
- `HALF_DIV`, 25: clk_100 cycles per PDM clock half-period (PDM clock = 2 MHz).
- `R`, 64: decimation ratio (PCM rate = 31.25 kHz).
- `WARMUP`, 4: decimated outputs suppressed after reset.
- `clk_100` input 1: system clock, 100 MHz.
- `rst_n` input 1: reset, synchronous, active-low; clock clk_100.
- `pdm_data_i` input 1: asynchronous PDM bit from the microphone.
- `pdm_clk_o` output 1: PDM clock to the microphone.
- `pdm_lrsel_o` output 1: microphone L/R select, tied 0.
- `data_mic` output 16: signed PCM sample, held between strobes.
- `data_mic_valid` output 1: one-cycle strobe, `data_mic` new this cycle.

## Operation
- Clock generator: counter `div_cnt` runs 0..HALF_DIV-1. At terminal count, `pdm_clk_o` toggles and `div_cnt` returns to 0.
- Input path: `pdm_data_i` passes through a 2-FF synchronizer.
- Sample tick: asserted for one cycle when `pdm_clk_o` toggles 1→0. The synchronized bit is mapped as 1→+1 and 0→−1 (sign-extended to 25 bits).
- Integrators: four cascaded 25-bit accumulators (`ACC_W` = 1 + 4·log2 R = 25), updated only on a sample tick.
  - Arithmetic is two's-complement and wraps modulo 2^25. No saturation is allowed here.
- Decimation counter: `dec_cnt` runs 0..R-1, incremented on each sample tick. A decimation tick occurs on the tick where it wraps R-1→0.
- Combs: four cascaded stages with differential delay 1, evaluated on each decimation tick. Each stage computes y = x − x_prev and stores x_prev.
- Output scaling: the comb output is arithmetically shifted right by 9 (`ACC_W` − 16). The result is then saturated to [−32768, 32767].
  - Constant full-scale +1 gives 2^24 >> 9 = 32768, which clips to 32767.
- Warm-up: `warm_cnt` counts decimation ticks up to WARMUP and then stays there. `data_mic_valid` and `data_mic` updates are suppressed while `warm_cnt` < WARMUP.
- FSM `state_t`, states WARM and RUN:
  - Reset puts the FSM in WARM.
  - WARM→RUN on the WARMUP-th decimation tick.
  - RUN is terminal until the next reset.

## Timing
- Reset values: `pdm_clk_o`=0, `pdm_lrsel_o`=0, `data_mic`=0, `data_mic_valid`=0. All accumulators, comb delays, `div_cnt`, `dec_cnt` and `warm_cnt` are 0. FSM is in WARM.
- `pdm_clk_o` first rises HALF_DIV cycles after reset is released. Its period is exactly 2·HALF_DIV = 50 cycles with 50% duty.
- Integrator update lands in the cycle after the sample tick.
- Comb chain is evaluated combinationally from the integrator-4 value. `data_mic` and `data_mic_valid` are registered in the cycle after the decimation tick: 1-cycle latency.
- Valid cadence in RUN: exactly one strobe every 2·HALF_DIV·R = 3200 cycles, never back-to-back. The first strobe follows the 5th decimation tick.
- `data_mic` changes only together with `data_mic_valid`=1.
- Reset mid-operation: on the next edge, all state returns to reset values. Any in-flight sample is discarded. The warm-up restarts in full.
- The synchronizer adds 2 cycles of delay. This is irrelevant because the sample point is 25 cycles after the rising edge, where the data is stable.

## Structure
- Shared package `audio_pkg` holds:
  - `state_t` (WARM, RUN);
  - `CIC_ORDER` = 4;
  - `ACC_W` = 25;
  - `PCM_W` = 16.
- The capture block imports `PCM_W` from `audio_pkg`.
- One sub-module, `pdm_clk_gen`: the divider plus synchronizer, outputting `pdm_clk_o`, the sample tick and the synchronized bit.
- Integrators, combs, warm-up FSM and output register live in `pdm_cic_decimator`.

## Test plan
- Reset then idle: check `pdm_clk_o` period 50 cycles with first rise at cycle 25. Check `pdm_lrsel_o`=0 and no valid strobe before the 5th decimation tick.
- Constant `pdm_data_i`=1: every strobe after warm-up gives `data_mic`=32767 (0x7FFF). Strobes are spaced exactly 3200 cycles apart.
- Constant `pdm_data_i`=0: every strobe after warm-up gives `data_mic`=−32768 (0x8000).
- Alternating 1/0 on successive PDM clocks: every strobe after warm-up gives `data_mic`=0.
- Reference model: drive a 75%-ones pattern (1,1,1,0 repeating). Steady output is 2^23 >> 9 = 16384 (0x4000). Check that long runs (≥ 10^6 ticks) show no wrap errors.
- Reset pulse mid-frame: `data_mic` and `data_mic_valid` go to 0 on the next edge. No strobe appears for the next 5 decimation periods. Output then matches the constant-stimulus values again.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio front-end definitions.
//   state_t   : warm-up FSM encoding for the PDM decimator (WARM, RUN)
//   CIC_ORDER : number of integrator / comb stages
//   ACC_W     : CIC accumulator width, 1 + CIC_ORDER*log2(64)
//   PCM_W     : PCM sample width delivered to the capture block
package audio_pkg;

    localparam int unsigned CIC_ORDER = 4;
    localparam int unsigned ACC_W     = 25;
    localparam int unsigned PCM_W     = 16;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM microphone clock divider and input synchronizer.
//   clk_100       : system clock
//   rst_n         : synchronous active-low reset
//   pdm_data_i    : asynchronous PDM bit from the microphone
//   pdm_clk_o     : PDM clock, toggles every HALF_DIV cycles, starts low
//   sample_tick_o : one-cycle pulse in the cycle where pdm_clk_o falls
//   pdm_bit_o     : synchronized PDM bit
module pdm_clk_gen #(
    parameter int unsigned HALF_DIV = 25
) (
    input  logic clk_100,
    input  logic rst_n,
    input  logic pdm_data_i,
    output logic pdm_clk_o,
    output logic sample_tick_o,
    output logic pdm_bit_o
);

    localparam int unsigned DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pclk_q, pclk_d;
    logic [1:0]       sync_q;
    logic             terminal;

    always_comb begin
        terminal  = (div_cnt_q == DIV_W'(HALF_DIV - 1));
        div_cnt_d = terminal ? '0 : div_cnt_q + DIV_W'(1);
        pclk_d    = terminal ? ~pclk_q : pclk_q;
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            pclk_q    <= 1'b0;
            sync_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pclk_q    <= pclk_d;
            sync_q    <= {sync_q[0], pdm_data_i};
        end
    end

    assign pdm_clk_o     = pclk_q;
    // The falling edge of the PDM clock is the mid-point of the data eye.
    assign sample_tick_o = terminal & pclk_q;
    assign pdm_bit_o     = sync_q[1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: drives the mic clock, samples the PDM stream
// and decimates it with a 4th-order CIC into signed 16-bit PCM.
//   clk_100        : system clock, 100 MHz
//   rst_n          : synchronous active-low reset
//   pdm_data_i     : asynchronous PDM bit from the microphone
//   pdm_clk_o      : PDM clock to the microphone
//   pdm_lrsel_o    : microphone L/R select, tied low
//   data_mic       : signed PCM sample, held between strobes
//   data_mic_valid : one-cycle strobe, data_mic new this cycle
module pdm_cic_decimator
    import audio_pkg::*;
#(
    parameter int unsigned HALF_DIV = 25,
    parameter int unsigned R        = 64,
    parameter int unsigned WARMUP   = 4
) (
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic             pdm_data_i,
    output logic             pdm_clk_o,
    output logic             pdm_lrsel_o,
    output logic [PCM_W-1:0] data_mic,
    output logic             data_mic_valid
);

    localparam int unsigned DEC_W  = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int unsigned SHIFT  = ACC_W - PCM_W;

    localparam logic [ACC_W-1:0] AMBIG  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W:0]   POS_FS = {2'b01, {(ACC_W-1){1'b0}}};

    logic sample_tick;
    logic pdm_bit;

    pdm_clk_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_clk_gen (
        .clk_100      (clk_100),
        .rst_n        (rst_n),
        .pdm_data_i   (pdm_data_i),
        .pdm_clk_o    (pdm_clk_o),
        .sample_tick_o(sample_tick),
        .pdm_bit_o    (pdm_bit)
    );

    logic [CIC_ORDER-1:0][ACC_W-1:0] integ_q, integ_d;
    logic [CIC_ORDER-1:0][ACC_W-1:0] comb_prev_q, comb_prev_d;
    logic [DEC_W-1:0]                dec_cnt_q, dec_cnt_d;
    logic [WARM_W-1:0]               warm_cnt_q, warm_cnt_d;
    logic                            last_bit_q, last_bit_d;
    logic [PCM_W-1:0]                data_mic_q, data_mic_d;
    logic                            valid_q, valid_d;
    state_t                          state_q, state_d;

    logic                  dec_tick;
    logic                  out_en;
    logic [ACC_W-1:0]      x_in;
    logic [ACC_W-1:0]      int_carry;
    logic [ACC_W-1:0]      comb_acc;
    logic signed [ACC_W:0] comb_ext;
    logic signed [ACC_W:0] comb_shr;

    // 1 -> +1, 0 -> -1 in two's complement.
    assign x_in     = {{(ACC_W-1){~pdm_bit}}, 1'b1};
    assign dec_tick = sample_tick && (dec_cnt_q == DEC_W'(R - 1));

    // Integrators: each stage adds the freshly updated value of the one before.
    always_comb begin
        integ_d   = integ_q;
        int_carry = x_in;
        if (sample_tick) begin
            for (int unsigned i = 0; i < CIC_ORDER; i++) begin
                integ_d[i] = integ_q[i] + int_carry;
                int_carry  = integ_d[i];
            end
        end
    end

    // Combs run off the registered last integrator on each decimation tick.
    always_comb begin
        comb_prev_d = comb_prev_q;
        comb_acc    = integ_q[CIC_ORDER-1];
        for (int unsigned i = 0; i < CIC_ORDER; i++) begin
            if (dec_tick) comb_prev_d[i] = comb_acc;
            comb_acc = comb_acc - comb_prev_q[i];
        end
    end

    // Full scale +2^24 and -2^24 share one 25-bit pattern after wrapping.
    // That pattern only occurs when every sample in the filter window is
    // equal, so the most recent accumulated bit tells which one it is.
    always_comb begin
        comb_ext = (comb_acc == AMBIG && last_bit_q) ? POS_FS
                                                     : {comb_acc[ACC_W-1], comb_acc};
        comb_shr = comb_ext >>> SHIFT;
        if (comb_shr[ACC_W:PCM_W-1] == '0 || comb_shr[ACC_W:PCM_W-1] == '1) begin
            data_mic_d = comb_shr[PCM_W-1:0];
        end else begin
            data_mic_d = comb_shr[ACC_W] ? {1'b1, {(PCM_W-1){1'b0}}}
                                         : {1'b0, {(PCM_W-1){1'b1}}};
        end
        if (!(dec_tick && out_en)) data_mic_d = data_mic_q;
        valid_d = dec_tick && out_en;
    end

    always_comb begin
        last_bit_d = sample_tick ? pdm_bit : last_bit_q;
        dec_cnt_d  = dec_cnt_q;
        if (sample_tick) begin
            dec_cnt_d = (dec_cnt_q == DEC_W'(R - 1)) ? '0 : dec_cnt_q + DEC_W'(1);
        end
        warm_cnt_d = warm_cnt_q;
        if (dec_tick && warm_cnt_q < WARM_W'(WARMUP)) begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
    end

    // Warm-up FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WARM:    if (dec_tick && warm_cnt_q == WARM_W'(WARMUP - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = WARM;
        endcase
    end

    // Warm-up FSM: outputs
    always_comb begin
        out_en = (state_q == RUN);
    end

    // Warm-up FSM: state register
    always_ff @(posedge clk_100) begin
        if (!rst_n) state_q <= WARM;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            integ_q     <= '0;
            comb_prev_q <= '0;
            dec_cnt_q   <= '0;
            warm_cnt_q  <= '0;
            last_bit_q  <= 1'b0;
            data_mic_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            comb_prev_q <= comb_prev_d;
            dec_cnt_q   <= dec_cnt_d;
            warm_cnt_q  <= warm_cnt_d;
            last_bit_q  <= last_bit_d;
            data_mic_q  <= data_mic_d;
            valid_q     <= valid_d;
        end
    end

    assign pdm_lrsel_o    = 1'b0;
    assign data_mic       = data_mic_q;
    assign data_mic_valid = valid_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench for pdm_cic_decimator. The reference model treats the
// CIC as its impulse response (boxcar of length R convolved with itself
// four times) applied to the +/-1 sample history, in unbounded arithmetic.
module tb_pdm_cic_decimator;

    localparam int HALF_DIV = 25;
    localparam int R        = 64;
    localparam int WARMUP   = 4;
    localparam int NTAP     = 4 * (R - 1) + 1;
    localparam int STROBE_T = 2 * HALF_DIV * R;

    logic        clk_100 = 1'b0;
    logic        rst_n   = 1'b0;
    logic        pdm_data_i = 1'b0;
    logic        pdm_clk_o;
    logic        pdm_lrsel_o;
    logic [15:0] data_mic;
    logic        data_mic_valid;

    pdm_cic_decimator #(
        .HALF_DIV(HALF_DIV),
        .R       (R),
        .WARMUP  (WARMUP)
    ) dut (
        .clk_100       (clk_100),
        .rst_n         (rst_n),
        .pdm_data_i    (pdm_data_i),
        .pdm_clk_o     (pdm_clk_o),
        .pdm_lrsel_o   (pdm_lrsel_o),
        .data_mic      (data_mic),
        .data_mic_valid(data_mic_valid)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    int     checks = 0;
    int     errors = 0;
    longint h[NTAP];
    bit     bits[$];
    int     exp_q[$];

    // Requests from the stimulus process, serviced by the monitor.
    int req_reset_chk = 0;
    int req_timeout   = 0;
    bit req_drain     = 1'b0;

    function automatic void build_h();
        longint cur[NTAP];
        longint nxt[NTAP];
        for (int m = 0; m < NTAP; m++) cur[m] = 0;
        cur[0] = 1;
        for (int s = 0; s < 4; s++) begin
            for (int m = 0; m < NTAP; m++) begin
                nxt[m] = 0;
                for (int i = 0; i < R; i++) if (m >= i) nxt[m] += cur[m - i];
            end
            cur = nxt;
        end
        h = cur;
    endfunction

    // Output for the decimation whose newest included sample is n (1-based).
    function automatic int model_out(int n);
        longint acc = 0;
        for (int m = 0; m < NTAP; m++) begin
            int k = n - m;
            if (k >= 1) acc += bits[k - 1] ? h[m] : -h[m];
        end
        acc = acc >>> 9;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    task automatic wait_rise(output bit ok);
        bit prev = pdm_clk_o;
        ok = 1'b0;
        for (int i = 0; i < 4 * HALF_DIV; i++) begin
            @(posedge clk_100);
            #1;
            if (pdm_clk_o && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = pdm_clk_o;
        end
    endtask

    // mode 0: 1s, 0s, alternating, 1110 pattern, random; mode 1: all ones.
    task automatic run_samples(input int n, input int mode);
        bit ok;
        bit b;
        for (int k = 1; k <= n; k++) begin
            wait_rise(ok);
            if (!ok) begin
                req_timeout++;
                break;
            end
            if (mode == 1 || k <= 320) b = 1'b1;
            else if (k <= 576)         b = 1'b0;
            else if (k <= 832)         b = k[0];
            else if (k <= 1088)        b = ((k % 4) != 0);
            else                       b = bit'($urandom());
            pdm_data_i = b;
            bits.push_back(b);
            if ((k + 1) % R == 0 && (k + 1) / R > WARMUP) exp_q.push_back(model_out(k));
        end
    endtask

    initial begin
        build_h();
        rst_n      = 1'b0;
        pdm_data_i = 1'b0;
        repeat (3) @(posedge clk_100);
        #1;
        req_reset_chk++;
        @(posedge clk_100);
        #1;
        rst_n = 1'b1;

        run_samples(1248, 0);

        // Reset in the middle of a decimation period.
        rst_n = 1'b0;
        exp_q.delete();
        bits.delete();
        @(posedge clk_100);
        #1;
        req_reset_chk++;
        repeat (2) @(posedge clk_100);
        #1;
        rst_n = 1'b1;

        run_samples(384, 1);

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk_100);
        #1;
        req_drain = 1'b1;
        repeat (3) @(negedge clk_100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: scoreboard pops, strobe cadence, hold, PDM clock half-periods.
    int          seen_reset_chk = 0;
    int          seen_timeout   = 0;
    bit          drain_seen     = 1'b0;
    int          last_strobe    = -1;
    int          last_chg       = 0;
    logic        prev_pclk      = 1'b0;
    logic [15:0] prev_data      = '0;
    int          e;

    always @(negedge clk_100) begin
        if (req_reset_chk != seen_reset_chk) begin
            seen_reset_chk = req_reset_chk;
            checks++;
            if (data_mic !== 16'h0 || data_mic_valid !== 1'b0 || pdm_clk_o !== 1'b0
                || pdm_lrsel_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: data_mic=%h valid=%b pdm_clk=%b lrsel=%b, required 0 0 0 0",
                         data_mic, data_mic_valid, pdm_clk_o, pdm_lrsel_o);
            end
        end
        if (req_timeout != seen_timeout) begin
            seen_timeout = req_timeout;
            checks++;
            errors++;
            $display("FAIL pdm_clk_timeout: no pdm_clk_o rise within %0d cycles", 4 * HALF_DIV);
        end
        if (req_drain && !drain_seen) begin
            drain_seen = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_strobe: %0d expected samples never strobed, required 0",
                         exp_q.size());
            end
        end

        if (!rst_n) begin
            last_strobe = -1;
            last_chg    = cyc + 1;
            prev_pclk   = pdm_clk_o;
            prev_data   = '0;
        end else begin
            if (pdm_clk_o !== prev_pclk) begin
                checks++;
                if (cyc - last_chg != HALF_DIV) begin
                    errors++;
                    $display("FAIL pdm_half_period: got %0d cycles, required %0d",
                             cyc - last_chg, HALF_DIV);
                end
                last_chg  = cyc;
                prev_pclk = pdm_clk_o;
            end

            if (data_mic_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: data_mic=%h at cycle %0d, required no strobe",
                             data_mic, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (data_mic !== 16'(e)) begin
                        errors++;
                        $display("FAIL pcm_sample: got %0d, required %0d",
                                 $signed(data_mic), e);
                    end
                end
                if (last_strobe >= 0) begin
                    checks++;
                    if (cyc - last_strobe != STROBE_T) begin
                        errors++;
                        $display("FAIL strobe_spacing: got %0d cycles, required %0d",
                                 cyc - last_strobe, STROBE_T);
                    end
                end
                last_strobe = cyc;
                checks++;
                if (pdm_lrsel_o !== 1'b0) begin
                    errors++;
                    $display("FAIL lrsel: got %b, required 0", pdm_lrsel_o);
                end
            end else begin
                checks++;
                if (data_mic !== prev_data) begin
                    errors++;
                    $display("FAIL data_hold: data_mic changed to %h without strobe, required %h",
                             data_mic, prev_data);
                end
            end
            prev_data = data_mic;
        end
    end

endmodule
